// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit ripple-carry adder split into SEG-bit segments,
// one segment added per pipeline stage with the carry registered in between.
// Valid/ready handshake on both sides; the whole pipe stalls as one unit.
// Optional subtract mode is enabled by defining PIPE_ADDER_SUB_EN, which adds
// the 'sub' input (a - b computed as a + ~b + 1, cin ignored).
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
`ifdef PIPE_ADDER_SUB_EN
  ,
  input  logic             sub
`endif
);

  localparam int STAGES = WIDTH / SEG;

  generate
    if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH must be a non-zero multiple of SEG");
    end
  endgenerate

  // One SEG-bit ripple segment: returns {carry_out, segment_sum}.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    seg_add = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
  endfunction

  // Pipeline registers. p_r holds finished sum segments below the stage's
  // segment and still-unused operand-A segments above it.
  logic [WIDTH-1:0]  p_r   [0:STAGES-1];
  logic [WIDTH-1:0]  b_r   [0:STAGES-1];
  logic              sub_r [0:STAGES-1];
  logic [STAGES-1:0] c_r;
  logic [STAGES-1:0] vld_r;
  logic              ovf_r;

  // Stage inputs / next-state values.
  logic [WIDTH-1:0]  pi_s [0:STAGES-1];
  logic [WIDTH-1:0]  bi_s [0:STAGES-1];
  logic [WIDTH-1:0]  pn_s [0:STAGES-1];
  logic              si_s [0:STAGES-1];
  logic [STAGES-1:0] ci_s;
  logic [STAGES-1:0] cn_s;
  logic [STAGES-1:0] vi_s;
  logic [SEG-1:0]    beff_s;
  logic [SEG:0]      res_s;
  logic              ovf_s;
  logic              sub_s;
  logic              advance_s;

`ifdef PIPE_ADDER_SUB_EN
  assign sub_s = sub;
`else
  assign sub_s = 1'b0;
`endif

  assign advance_s = !vld_r[STAGES-1] || out_ready;
  assign in_ready  = advance_s;
  assign out_valid = vld_r[STAGES-1];
  assign sum       = p_r[STAGES-1];
  assign cout      = c_r[STAGES-1];
  assign ovf       = ovf_r;

  // Route stage inputs and compute every segment add plus MSB-column overflow.
  always_comb begin
    pi_s[0] = a;
    bi_s[0] = b;
    si_s[0] = sub_s;
    vi_s[0] = in_valid;
    if (sub_s) begin
      ci_s[0] = 1'b1;
    end else begin
      ci_s[0] = cin;
    end
    for (int k = 1; k < STAGES; k++) begin
      pi_s[k] = p_r[k-1];
      bi_s[k] = b_r[k-1];
      si_s[k] = sub_r[k-1];
      ci_s[k] = c_r[k-1];
      vi_s[k] = vld_r[k-1];
    end
    beff_s = {SEG{1'b0}};
    res_s  = {(SEG+1){1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      // Subtraction inverts every segment of its own operand B.
      beff_s  = bi_s[k][k*SEG +: SEG] ^ {SEG{si_s[k]}};
      res_s   = seg_add(pi_s[k][k*SEG +: SEG], beff_s, ci_s[k]);
      pn_s[k] = pi_s[k];
      pn_s[k][k*SEG +: SEG] = res_s[SEG-1:0];
      cn_s[k] = res_s[SEG];
    end
    // After the loop beff_s/res_s belong to the top segment: the carry into
    // the MSB column is recovered from the MSB sum bit and its operands.
    ovf_s = (pi_s[STAGES-1][WIDTH-1] ^ beff_s[SEG-1] ^ res_s[SEG-1]) ^ res_s[SEG];
  end

  // Shift the whole pipe on advance; hold every stage otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= {STAGES{1'b0}};
      c_r   <= {STAGES{1'b0}};
      ovf_r <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        p_r[k]   <= {WIDTH{1'b0}};
        b_r[k]   <= {WIDTH{1'b0}};
        sub_r[k] <= 1'b0;
      end
    end else if (advance_s) begin
      vld_r <= vi_s;
      c_r   <= cn_s;
      ovf_r <= ovf_s;
      for (int k = 0; k < STAGES; k++) begin
        p_r[k]   <= pn_s[k];
        b_r[k]   <= bi_s[k];
        sub_r[k] <= si_s[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, SEG=4, latency 4).
// Expected results come from a behavioural model, queued at accept and
// compared by a monitor whenever a result is presented.
module tb_pipelined_adder;

  localparam int WIDTH = 16;
  localparam int SEG   = 4;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
`ifdef PIPE_ADDER_SUB_EN
  logic        sub;
`endif

  res_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   nout   = 0;

  pipelined_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
`ifdef PIPE_ADDER_SUB_EN
    , .sub(sub)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: plain 17-bit addition, overflow by the sign rule.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic sb);
    logic [15:0] yy;
    logic        c;
    logic [16:0] t;
    res_t        r;
    yy = sb ? ~y : y;
    c  = sb ? 1'b1 : ci;
    t  = {1'b0, x} + {1'b0, yy} + {16'd0, c};
    r.sum  = t[15:0];
    r.cout = t[16];
    r.ovf  = (x[15] == yy[15]) && (t[15] != x[15]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: compare presented result with scoreboard head; pop on transfer.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_output observed sum=%0h expected none", sum);
      end else begin
        checks++;
        assert ({sum, cout, ovf} === {q[0].sum, q[0].cout, q[0].ovf}) else begin
          errors++;
          $error("FAIL result observed sum=%0h cout=%0b ovf=%0b expected sum=%0h cout=%0b ovf=%0b",
                 sum, cout, ovf, q[0].sum, q[0].cout, q[0].ovf);
        end
        if (out_ready === 1'b1) begin
          void'(q.pop_front());
          nout++;
        end
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb);
    int w;
    w = 0;
    @(posedge clk); #1;
    a = x; b = y; cin = ci; in_valid = 1'b1;
`ifdef PIPE_ADDER_SUB_EN
    sub = sb;
`endif
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept", {31'd0, in_ready}, 32'd1);
    if (in_ready) q.push_back(model(x, y, ci, sb));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 60) begin
      @(posedge clk);
      w++;
    end
    chk("drain", q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int i;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 16'd0; b = 16'd0; cin = 1'b0;
`ifdef PIPE_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_sum",       {16'd0, sum},       32'd0);
    chk("rst_cout",      {31'd0, cout},      32'd0);
    chk("rst_ovf",       {31'd0, ovf},       32'd0);

    // Carry ripple through all four stages, with latency check.
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("lat_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_on_time", {31'd0, out_valid}, 32'd1);
    chk("ripple_sum", {16'd0, sum}, 32'h0000);
    chk("ripple_cout", {31'd0, cout}, 32'd1);
    drain();

    // Signed overflow and other patterns.
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h8000, 16'h8000, 1'b0, 1'b0);
    send(16'h1234, 16'h4321, 1'b1, 1'b0);
    send(16'h0F0F, 16'hF0F0, 1'b0, 1'b0);
    drain();

    // Back-to-back stream of 8 with a 3-cycle output stall.
    base = nout;
    i = 0;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 4 && c <= 6);
      if (i < 8) begin
        in_valid = 1'b1; a = i[15:0]; b = 16'h1000; cin = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c >= 4 && c <= 6) begin
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      end
      if (in_valid && in_ready) begin
        q.push_back(model(i[15:0], 16'h1000, 1'b0, 1'b0));
        i++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("stream_accepts", i, 32'd8);
    chk("stream_outputs", nout - base, 32'd8);

    // Reset mid-flight: two accepts discarded, only the post-reset one emerges.
    @(posedge clk); #1;
    in_valid = 1'b1; a = 16'h0100; b = 16'h0200; cin = 1'b0;
    @(posedge clk); #1;
    a = 16'h0300; b = 16'h0400;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sum", {16'd0, sum}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    base = nout;
    send(16'h0001, 16'h0002, 1'b0, 1'b0);
    drain();
    repeat (6) @(posedge clk);
    chk("midrst_outputs", nout - base, 32'd1);

`ifdef PIPE_ADDER_SUB_EN
    send(16'h0005, 16'h0007, 1'b1, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    send(16'h0009, 16'h0003, 1'b0, 1'b0);
    drain();
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
